// File: rtl/ps2_break_decoder_pkg.sv
// ps2_break_decoder_pkg
//   Shared definitions for the PS/2 break-code decoder: frame FSM state
//   encoding, the PS/2 prefix bytes and the scancodes used downstream.
package ps2_break_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_e;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_TAB    = 8'h0D;
   localparam logic [7:0] SC_L      = 8'h4B;
   localparam logic [7:0] SC_D      = 8'h23;
   localparam logic [7:0] SC_A      = 8'h1C;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
//   Synchronises the raw PS/2 clock/data pair, detects ps2_clk falling edges
//   and assembles 11-bit frames (start, 8 data LSB first, odd parity, stop).
//   An in-progress frame is abandoned after TIMEOUT_CYCLES system clocks
//   without a ps2_clk fall.
// Ports:
//   clock      in   system clock, posedge
//   reset      in   asynchronous active-high reset
//   ps2_clk    in   raw keyboard clock (asynchronous)
//   ps2_data   in   raw keyboard data (asynchronous)
//   byte_out   out  last correctly framed byte
//   byte_valid out  one-cycle pulse per good frame
//   frame_err  out  one-cycle pulse per rejected or timed-out frame
module ps2_frame_rx
   import ps2_break_decoder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
   logic                   clk_prev_q;
   logic                   clk_s, data_s, fall;

   rx_state_e              state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             sr_q, sr_d;
   logic                   par_q, par_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [7:0]             byte_q, byte_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];
   assign fall   = clk_prev_q & ~clk_s;

   // Sync flops reset to the idle-high line level so release of reset
   // never manufactures a falling edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
         clk_prev_q  <= clk_s;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      par_d     = par_q;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      // Saturating idle-time counter; cleared by any fall or while idle.
      if (state_q == IDLE || fall) begin
         tmo_d = '0;
      end else if (tmo_q != TMO_MAX) begin
         tmo_d = tmo_q + TMO_W'(1);
      end else begin
         tmo_d = tmo_q;
      end

      // A fall in the same cycle as the timeout limit takes priority.
      if (fall) begin
         case (state_q)
            IDLE: begin
               if (!data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
            DATA: begin
               sr_d      = {data_s, sr_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = data_s;
               state_d = STOP;
            end
            STOP: begin
               if (data_s && (^{sr_q, par_q})) begin
                  byte_d  = sr_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && tmo_q == TMO_MAX) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= 3'd0;
         sr_q      <= 8'd0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
         byte_q    <= 8'd0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         par_q     <= par_d;
         tmo_q     <= tmo_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = valid_q;
   assign frame_err  = err_q;

endmodule

// File: rtl/ps2_break_decoder.sv
// ps2_break_decoder
//   PS/2 receiver plus break-prefix tracking. Each key release (0xF0 followed
//   by a scancode) yields inPress = {8'hF0, scancode} with a one-cycle key
//   strobe. Make codes, typematic repeats and the 0xE0 prefix produce no key.
// Ports:
//   clock      in   system clock, posedge
//   reset      in   asynchronous active-high reset
//   ps2_clk    in   raw keyboard clock (asynchronous)
//   ps2_data   in   raw keyboard data (asynchronous)
//   inPress    out  last break code; holds between strobes
//   key        out  one-cycle strobe, inPress valid in the same cycle
//   byte_out   out  last correctly framed byte (debug)
//   byte_valid out  one-cycle pulse per good frame
//   frame_err  out  one-cycle pulse per rejected frame
module ps2_break_decoder
   import ps2_break_decoder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] inPress,
   output logic        key,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        frame_err
);

   logic        break_pend_q, break_pend_d;
   logic [15:0] inpress_q;
   logic        is_prefix;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_frame_rx (
      .clock      (clock),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   // key is decoded in the byte_valid cycle so both strobe together; inPress
   // bypasses the new code in that cycle and holds the register otherwise.
   always_comb begin
      is_prefix    = (byte_out == PS2_BREAK) || (byte_out == PS2_EXT);
      key          = byte_valid && break_pend_q && !is_prefix;
      inPress      = key ? {PS2_BREAK, byte_out} : inpress_q;
      break_pend_d = break_pend_q;
      if (frame_err) begin
         break_pend_d = 1'b0;
      end else if (byte_valid) begin
         if (byte_out == PS2_BREAK) begin
            break_pend_d = 1'b1;
         end else if (byte_out != PS2_EXT) begin
            break_pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         break_pend_q <= 1'b0;
         inpress_q    <= 16'd0;
      end else begin
         break_pend_q <= break_pend_d;
         inpress_q    <= inPress;
      end
   end

endmodule

// File: tb/tb_ps2_break_decoder.sv
// tb_ps2_break_decoder
//   Drives PS/2 frames (directed plus random) into ps2_break_decoder and
//   compares pulse counts and held values against a frame-level model.
module tb_ps2_break_decoder;

   localparam int unsigned TMO = 300;

   logic        clock = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] inPress;
   logic        key;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        frame_err;

   ps2_break_decoder #(
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .inPress    (inPress),
      .key        (key),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Observed pulse activity
   int key_cnt = 0, bv_cnt = 0, fe_cnt = 0;
   int key_consec = 0, bv_consec = 0, fe_consec = 0;
   logic key_p = 1'b0, bv_p = 1'b0, fe_p = 1'b0;

   always @(negedge clock) begin
      if (key) begin
         key_cnt++;
         if (key_p) key_consec++;
      end
      if (byte_valid) begin
         bv_cnt++;
         if (bv_p) bv_consec++;
      end
      if (frame_err) begin
         fe_cnt++;
         if (fe_p) fe_consec++;
      end
      key_p = key;
      bv_p  = byte_valid;
      fe_p  = frame_err;
   end

   // Frame-level reference model
   int          exp_key = 0, exp_bv = 0, exp_fe = 0;
   logic        exp_pend = 1'b0;
   logic [15:0] exp_inpress = 16'd0;
   logic [7:0]  exp_byte = 8'd0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_frame(input logic [7:0] b, input logic good);
      if (!good) begin
         exp_fe++;
         exp_pend = 1'b0;
      end else begin
         exp_bv++;
         exp_byte = b;
         if (b == 8'hF0) begin
            exp_pend = 1'b1;
         end else if (b != 8'hE0) begin
            if (exp_pend) begin
               exp_key++;
               exp_inpress = {8'hF0, b};
            end
            exp_pend = 1'b0;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      @(negedge clock);
      #1;
      check_val({tag, "_key_cnt"}, key_cnt, exp_key);
      check_val({tag, "_bv_cnt"}, bv_cnt, exp_bv);
      check_val({tag, "_fe_cnt"}, fe_cnt, exp_fe);
      check_val({tag, "_inPress"}, 32'(inPress), 32'(exp_inpress));
      check_val({tag, "_byte_out"}, 32'(byte_out), 32'(exp_byte));
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (5) @(posedge clock);
      ps2_clk = 1'b0;
      repeat (10) @(posedge clock);
      ps2_clk = 1'b1;
      repeat (5) @(posedge clock);
   endtask

   task automatic send_raw(input logic [7:0] b, input logic par_flip, input logic stop_val);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ par_flip);
      ps2_bit(stop_val);
      ps2_data = 1'b1;
      repeat (5) @(posedge clock);
   endtask

   task automatic frame(input logic [7:0] b, input logic par_flip, input logic stop_val,
                        input string tag);
      send_raw(b, par_flip, stop_val);
      model_frame(b, !par_flip && stop_val);
      compare_all(tag);
   endtask

   // n falling edges of a frame, then the line idles until the timeout fires
   task automatic partial(input int n, input string tag);
      for (int i = 0; i < n; i++) ps2_bit(i == 0 ? 1'b0 : 1'($urandom_range(1)));
      ps2_data = 1'b1;
      repeat (TMO + 50) @(posedge clock);
      exp_fe++;
      exp_pend = 1'b0;
      compare_all(tag);
   endtask

   task automatic spurious(input string tag);
      ps2_bit(1'b1);
      repeat (5) @(posedge clock);
      exp_fe++;
      exp_pend = 1'b0;
      compare_all(tag);
   endtask

   logic [7:0] pool [0:9];

   initial begin
      pool = '{8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h1C, 8'h5A, 8'h0D, 8'h4B, 8'h23, 8'h2C};
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_val("rst_inPress", 32'(inPress), 32'd0);
      check_val("rst_key", 32'(key), 32'd0);
      check_val("rst_byte_out", 32'(byte_out), 32'd0);
      check_val("rst_bv", 32'(byte_valid), 32'd0);
      check_val("rst_fe", 32'(frame_err), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clock);

      // A press then release
      frame(8'h1C, 1'b0, 1'b1, "a_make");
      frame(8'hF0, 1'b0, 1'b1, "a_brk");
      frame(8'h1C, 1'b0, 1'b1, "a_rel");

      // Bad parity on the prefix clears the pending break
      frame(8'h5A, 1'b0, 1'b1, "ent_make");
      frame(8'hF0, 1'b1, 1'b1, "ent_badpar");
      frame(8'h5A, 1'b0, 1'b1, "ent_rel");

      // Timeout after a pending break clears it; then a clean release
      frame(8'hF0, 1'b0, 1'b1, "to_brk");
      partial(4, "to_4falls");
      frame(8'h2C, 1'b0, 1'b1, "to_nokey");
      frame(8'hF0, 1'b0, 1'b1, "to_brk2");
      frame(8'h2C, 1'b0, 1'b1, "to_rel");

      // Reset mid-frame
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b1);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_val("mid_rst_inPress", 32'(inPress), 32'd0);
      check_val("mid_rst_key", 32'(key), 32'd0);
      check_val("mid_rst_byte_out", 32'(byte_out), 32'd0);
      check_val("mid_rst_bv", 32'(byte_valid), 32'd0);
      check_val("mid_rst_fe", 32'(frame_err), 32'd0);
      reset = 1'b0;
      exp_pend    = 1'b0;
      exp_inpress = 16'd0;
      exp_byte    = 8'd0;
      repeat (3) @(posedge clock);
      frame(8'h23, 1'b0, 1'b1, "post_rst");

      // Extended prefix leaves break pending
      frame(8'hE0, 1'b0, 1'b1, "ext_e0");
      frame(8'hF0, 1'b0, 1'b1, "ext_f0");
      frame(8'h4B, 1'b0, 1'b1, "ext_rel");

      // Bad stop bit
      frame(8'hF0, 1'b0, 1'b0, "bad_stop");

      // Spurious fall in idle with data high
      spurious("spur");

      // Typematic repeats
      for (int i = 0; i < 10; i++) frame(8'h1C, 1'b0, 1'b1, "typ_rep");
      frame(8'hF0, 1'b0, 1'b1, "typ_brk");
      frame(8'h1C, 1'b0, 1'b1, "typ_rel");

      // Random mix
      for (int i = 0; i < 40; i++) begin
         int unsigned r;
         logic [7:0]  b;
         r = $urandom_range(99);
         b = ($urandom_range(9) == 0) ? 8'($urandom) : pool[$urandom_range(9)];
         if (r < 70)       frame(b, 1'b0, 1'b1, "rnd_good");
         else if (r < 80)  frame(b, 1'b1, 1'b1, "rnd_badpar");
         else if (r < 88)  frame(b, 1'b0, 1'b0, "rnd_badstop");
         else if (r < 94)  spurious("rnd_spur");
         else              partial(int'($urandom_range(10, 1)), "rnd_trunc");
      end

      check_val("key_consec", 32'(key_consec), 32'd0);
      check_val("bv_consec", 32'(bv_consec), 32'd0);
      check_val("fe_consec", 32'(fe_consec), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_break_decoder.md
Name: ps2_break_decoder

Overview:
- Upstream neighbour of the keyboard-programmed processor controller.
- Receives raw PS/2 keyboard frames on an asynchronous ps2_clk/ps2_data pair, checks framing and parity, and tracks the 0xF0 break prefix.
- Emits one 16-bit code {8'hF0, scancode} with a single-cycle key strobe per key release. The controller's inPress/key inputs consume this code directly.

Parameters:
- TIMEOUT_CYCLES, 100000: system clocks without a ps2_clk falling edge before an in-progress frame is abandoned (2 ms at 50 MHz).
- SYNC_STAGES, 2: synchroniser depth for ps2_clk and ps2_data; legal values 2..3.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw keyboard clock, asynchronous to clock.
- ps2_data  in  1  raw keyboard data, asynchronous to clock.
- inPress  out  16  last break code, {8'hF0, scancode}; holds between strobes.
- key  out  1  one-cycle pulse; inPress is valid in the same cycle.
- byte_out  out  8  last correctly framed byte, for debug/LEDs.
- byte_valid  out  1  one-cycle pulse per good frame.
- frame_err  out  1  one-cycle pulse per rejected frame.

Behaviour:
- Interface is fixed: single clock `clock`; reset `reset` is asynchronous and active-high.
- Reset values: inPress = 0, key = 0, byte_out = 0, byte_valid = 0, frame_err = 0, state = IDLE, break_pend = 0, counters = 0.
  - Reset asserted mid-frame discards the partial frame; no pulse is emitted.
- Synchronisation:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A falling edge is registered as (previous synced clk = 1) and (current synced clk = 0).
  - ps2_data is sampled only in a falling-edge cycle.
- Frame FSM, 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
  - IDLE: on a fall with data = 0, go to DATA with bit_cnt = 0. On a fall with data = 1, pulse frame_err and stay in IDLE.
  - DATA: on each fall, sr = {data, sr[7:1]} and bit_cnt increments. After the 8th bit, go to PARITY.
  - PARITY: on a fall, latch the parity bit p and go to STOP.
  - STOP: on a fall, the frame is good only if data = 1 and ^{sr, p} = 1.
    - Good frame: byte_out = sr, byte_valid pulses for one cycle.
    - Bad frame: frame_err pulses for one cycle.
    - Either way, return to IDLE.
- Timeout:
  - The counter runs while state != IDLE and clears on every fall and in IDLE.
  - On reaching TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear break_pend.
  - If a fall occurs in the same cycle the counter hits its limit, the fall wins: the bit is processed and no timeout is taken.
- Break decoder, acting on byte_valid:
  - Byte 8'hF0: set break_pend; no key pulse.
  - Byte 8'hE0: ignored; break_pend is unchanged.
  - Any other byte with break_pend = 1: inPress = {8'hF0, byte}, key = 1, break_pend = 0.
  - Any other byte with break_pend = 0: make or typematic repeat; discarded, no key pulse.
  - frame_err clears break_pend.
- Latency:
  - key asserts 1 cycle after the clock edge that registers the stop-bit fall.
  - byte_valid asserts in that same cycle.
- Pulse shape: key, byte_valid and frame_err are never high for two consecutive cycles. At most one key pulse per frame.
- Width rules:
  - Timeout counter width is clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
  - bit_cnt is 3 bits plus a state qualifier, so no wrap into the next frame.

Decomposition:
- Shared package/header holds:
  - FSM state encodings IDLE/DATA/PARITY/STOP (2 bits).
  - Constants PS2_BREAK = 8'hF0 and PS2_EXT = 8'hE0.
  - Scancode constants already used downstream: ENTER 8'h5A, TAB 8'h0D, L 8'h4B, D 8'h23, A 8'h1C.
- One sub-module, ps2_frame_rx, contains the synchroniser, edge detect, frame FSM, parity and timeout. It outputs byte_out, byte_valid and frame_err.
- The top level adds the break_pend register and the inPress/key stage.

Test Plan:
- Frames 0x1C, 0xF0, 0x1C (A press then release) -> exactly one key pulse, inPress = 16'hF01C. byte_valid pulses 3 times, frame_err stays 0.
- Frame 0x5A, then 0xF0 with wrong parity, then 0x5A -> frame_err pulses once, break_pend is cleared, no key pulse.
- Four falling edges of a frame, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulses once and FSM returns to IDLE. A following clean 0xF0, 0x2C yields inPress = 16'hF02C with key.
- Reset asserted after bit 5 of frame 0xF0, released, then 0x23 sent -> no key pulse (break_pend was 0), all outputs are 0 during reset.
- Sequence 0xE0, 0xF0, 0x4B -> one key pulse, inPress = 16'hF04B. Separately, a stop bit of 0 on byte 0xF0 -> frame_err and no byte_valid.
- Typematic: 0x1C repeated 10 times, then 0xF0, 0x1C -> exactly one key pulse. Check key never high on consecutive cycles.
